// File: rtl/load_store_unit.sv
// flintRV memory-stage load/store unit: one bus transaction per op.
// Optional LOAD_STORE_MISALIGN_TRAP_EN flags misaligned half/word ops.
module load_store_unit #(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_valid,
  input  logic            i_we,
  input  logic [2:0]      i_funct3,
  input  logic [XLEN-1:0] i_addr,
  input  logic [XLEN-1:0] i_wdata,
  output logic            o_stall,
  output logic            o_done,
  output logic [XLEN-1:0] o_rdata,
  output logic            o_misaligned,
  output logic            o_dbusReq,
  output logic            o_dbusWe,
  output logic [XLEN-1:0] o_dbusAddr,
  output logic [3:0]      o_dbusBe,
  output logic [XLEN-1:0] o_dbusWdata,
  input  logic            i_dbusAck,
  input  logic [XLEN-1:0] i_dbusRdata
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DONE
  } state_t;

  state_t state, state_nx;

  logic            we_q;
  logic [1:0]      size_q;
  logic            uns_q;
  logic [1:0]      off_q;
  logic [3:0]      be_nx;
  logic [XLEN-1:0] wdata_nx;
  logic [XLEN-1:0] ext;
  logic [7:0]      byte_sel;
  logic [15:0]     half_sel;
  logic            misal;
  logic            issue;

  always_comb begin
    be_nx    = 4'b1111;
    wdata_nx = i_wdata;
    unique case (1'b1)
      i_funct3[1]: begin
        be_nx    = 4'b1111;
        wdata_nx = i_wdata;
      end
      (i_funct3[1:0] == 2'b01): begin
        be_nx    = 4'b0011 << {i_addr[1], 1'b0};
        wdata_nx = {2{i_wdata[15:0]}};
      end
      (i_funct3[1:0] == 2'b00): begin
        be_nx    = 4'b0001 << i_addr[1:0];
        wdata_nx = {4{i_wdata[7:0]}};
      end
    endcase
  end

`ifdef LOAD_STORE_MISALIGN_TRAP_EN
  assign misal = (i_funct3[1:0] == 2'b01 && i_addr[0])
              || (i_funct3[1] && i_addr[1:0] != 2'b00);
`else
  assign misal = 1'b0;
`endif

  assign issue = (state == IDLE) && i_valid && !misal;

  // Extraction works on the offsets captured at issue time.
  always_comb begin
    byte_sel = i_dbusRdata[7:0];
    half_sel = off_q[1] ? i_dbusRdata[31:16] : i_dbusRdata[15:0];
    unique case (off_q)
      2'b00: byte_sel = i_dbusRdata[7:0];
      2'b01: byte_sel = i_dbusRdata[15:8];
      2'b10: byte_sel = i_dbusRdata[23:16];
      2'b11: byte_sel = i_dbusRdata[31:24];
    endcase
    ext = i_dbusRdata;
    unique case (1'b1)
      we_q:
        ext = '0;
      (!we_q && size_q[1]):
        ext = i_dbusRdata;
      (!we_q && size_q == 2'b01):
        ext = {{16{!uns_q && half_sel[15]}}, half_sel};
      (!we_q && size_q == 2'b00):
        ext = {{24{!uns_q && byte_sel[7]}}, byte_sel};
    endcase
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (issue) state_nx = REQ;
      REQ:  if (i_dbusAck) state_nx = DONE;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= IDLE;
      we_q        <= 1'b0;
      size_q      <= 2'b00;
      uns_q       <= 1'b0;
      off_q       <= 2'b00;
      o_dbusAddr  <= '0;
      o_dbusBe    <= 4'b0000;
      o_dbusWdata <= '0;
      o_rdata     <= '0;
    end else begin
      state <= state_nx;
      if (issue) begin
        we_q        <= i_we;
        size_q      <= i_funct3[1:0];
        uns_q       <= i_funct3[2];
        off_q       <= i_addr[1:0];
        o_dbusAddr  <= {i_addr[XLEN-1:2], 2'b00};
        o_dbusBe    <= be_nx;
        o_dbusWdata <= wdata_nx;
      end
      if (state == REQ && i_dbusAck) o_rdata <= ext;
    end
  end

  assign o_stall      = issue || (state == REQ);
  assign o_done       = (state == DONE);
  assign o_misaligned = (state == IDLE) && i_valid && misal;
  assign o_dbusReq    = (state == REQ);
  assign o_dbusWe     = (state == REQ) && we_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: loads, stores, waits, reset, alignment.
// Expected values are hand-computed per vector.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid;
  logic        we;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        stall;
  logic        done;
  logic [31:0] rdata;
  logic        misaligned;
  logic        dreq;
  logic        dwe;
  logic [31:0] daddr;
  logic [3:0]  dbe;
  logic [31:0] dwdata;
  logic        dack;
  logic [31:0] drdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  load_store_unit dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_valid      (valid),
    .i_we         (we),
    .i_funct3     (funct3),
    .i_addr       (addr),
    .i_wdata      (wdata),
    .o_stall      (stall),
    .o_done       (done),
    .o_rdata      (rdata),
    .o_misaligned (misaligned),
    .o_dbusReq    (dreq),
    .o_dbusWe     (dwe),
    .o_dbusAddr   (daddr),
    .o_dbusBe     (dbe),
    .o_dbusWdata  (dwdata),
    .i_dbusAck    (dack),
    .i_dbusRdata  (drdata)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one op with valid held until DONE; ack after 'waits' REQ cycles.
  task automatic run_op(
    input  logic        op_we,
    input  logic [2:0]  op_f3,
    input  logic [31:0] op_addr,
    input  logic [31:0] op_wd,
    input  int          waits,
    input  logic [31:0] bus_rd,
    output int          stalls,
    output int          dones,
    output int          txns,
    output logic [31:0] q_addr,
    output logic [3:0]  q_be,
    output logic [31:0] q_wd,
    output logic        q_we,
    output logic        stable,
    output logic [31:0] q_rdata
  );
    int  w;
    bit  seen_req;
    bit  seen_done;
    valid  = 1'b1;
    we     = op_we;
    funct3 = op_f3;
    addr   = op_addr;
    wdata  = op_wd;
    stalls = 0;
    dones  = 0;
    txns   = 0;
    stable = 1'b1;
    q_addr = '0;
    q_be   = '0;
    q_wd   = '0;
    q_we   = 1'b0;
    q_rdata = '0;
    w = 0;
    seen_req  = 0;
    seen_done = 0;
    for (int c = 0; c < waits + 8; c++) begin
      if (c > 0) begin
        tick();
        dack = 1'b0;
        if (seen_done) valid = 1'b0;
      end
      #1;
      if (stall) stalls++;
      if (done) begin
        dones++;
        q_rdata = rdata;
        seen_done = 1;
      end
      if (dreq) begin
        if (!seen_req) begin
          q_addr = daddr;
          q_be   = dbe;
          q_wd   = dwdata;
          q_we   = dwe;
          seen_req = 1;
        end else if (daddr !== q_addr || dbe !== q_be
                     || dwdata !== q_wd || dwe !== q_we) begin
          stable = 1'b0;
        end
        if (w == waits) begin
          dack   = 1'b1;
          drdata = bus_rd;
          txns++;
        end
        w++;
      end
    end
    tick();
    dack  = 1'b0;
    valid = 1'b0;
  endtask

  int          st, dn, tx;
  logic [31:0] qa, qw, qr;
  logic [3:0]  qb;
  logic        qwe, stab;

  initial begin
    rst    = 1'b1;
    valid  = 1'b0;
    we     = 1'b0;
    funct3 = 3'b010;
    addr   = '0;
    wdata  = '0;
    dack   = 1'b0;
    drdata = '0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_misal", {31'd0, misaligned}, 32'd0);
    chk("rst_req", {31'd0, dreq}, 32'd0);
    chk("rst_we", {31'd0, dwe}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_addr", daddr, 32'd0);
    chk("rst_be", {28'd0, dbe}, 32'd0);
    chk("rst_wdata", dwdata, 32'd0);
    tick();

    // LW 0x100, ack on first REQ cycle
    run_op(1'b0, 3'b010, 32'h100, 32'h0, 0, 32'hDEADBEEF,
           st, dn, tx, qa, qb, qw, qwe, stab, qr);
    chk("lw_addr", qa, 32'h100);
    chk("lw_be", {28'd0, qb}, 32'hF);
    chk("lw_we", {31'd0, qwe}, 32'd0);
    chk("lw_stalls", st, 32'd2);
    chk("lw_dones", dn, 32'd1);
    chk("lw_txns", tx, 32'd1);
    chk("lw_rdata", qr, 32'hDEADBEEF);

    // LB / LBU 0x103
    run_op(1'b0, 3'b000, 32'h103, 32'h0, 0, 32'h80123456,
           st, dn, tx, qa, qb, qw, qwe, stab, qr);
    chk("lb_addr", qa, 32'h100);
    chk("lb_be", {28'd0, qb}, 32'h8);
    chk("lb_rdata", qr, 32'hFFFFFF80);
    run_op(1'b0, 3'b100, 32'h103, 32'h0, 1, 32'h80123456,
           st, dn, tx, qa, qb, qw, qwe, stab, qr);
    chk("lbu_rdata", qr, 32'h00000080);
    chk("lbu_stalls", st, 32'd3);

    // LHU 0x102 upper half
    run_op(1'b0, 3'b101, 32'h102, 32'h0, 0, 32'h80123456,
           st, dn, tx, qa, qb, qw, qwe, stab, qr);
    chk("lhu_be", {28'd0, qb}, 32'hC);
    chk("lhu_rdata", qr, 32'h00008012);

    // SH 0x202, three wait cycles
    run_op(1'b1, 3'b001, 32'h202, 32'h0000ABCD, 3, 32'h12345678,
           st, dn, tx, qa, qb, qw, qwe, stab, qr);
    chk("sh_addr", qa, 32'h200);
    chk("sh_be", {28'd0, qb}, 32'hC);
    chk("sh_wdata", qw, 32'hABCDABCD);
    chk("sh_we", {31'd0, qwe}, 32'd1);
    chk("sh_stalls", st, 32'd5);
    chk("sh_stable", {31'd0, stab}, 32'd1);
    chk("sh_dones", dn, 32'd1);
    chk("sh_txns", tx, 32'd1);
    chk("sh_rdata", qr, 32'd0);

    // SB 0x201
    run_op(1'b1, 3'b000, 32'h201, 32'h1234565A, 0, 32'h0,
           st, dn, tx, qa, qb, qw, qwe, stab, qr);
    chk("sb_be", {28'd0, qb}, 32'h2);
    chk("sb_wdata", qw, 32'h5A5A5A5A);

`ifdef LOAD_STORE_MISALIGN_TRAP_EN
    valid  = 1'b1;
    we     = 1'b0;
    funct3 = 3'b001;
    addr   = 32'h101;
    #1;
    chk("mis_pulse", {31'd0, misaligned}, 32'd1);
    chk("mis_stall", {31'd0, stall}, 32'd0);
    tick();
    valid = 1'b0;
    #1;
    chk("mis_req", {31'd0, dreq}, 32'd0);
    chk("mis_after", {31'd0, misaligned}, 32'd0);
    tick();
    chk("mis_done", {31'd0, done}, 32'd0);
`else
    run_op(1'b0, 3'b001, 32'h101, 32'h0, 0, 32'h1234F678,
           st, dn, tx, qa, qb, qw, qwe, stab, qr);
    chk("lh_mis_addr", qa, 32'h100);
    chk("lh_mis_be", {28'd0, qb}, 32'h3);
    chk("lh_mis_rdata", qr, 32'hFFFFF678);
    chk("lh_mis_flag", {31'd0, misaligned}, 32'd0);
`endif

    // Reset during REQ; late ack must be ignored
    valid  = 1'b1;
    we     = 1'b1;
    funct3 = 3'b010;
    addr   = 32'h344;
    wdata  = 32'hCAFEF00D;
    tick();
    #1;
    chk("rr_req", {31'd0, dreq}, 32'd1);
    rst   = 1'b1;
    valid = 1'b0;
    tick();
    rst    = 1'b0;
    dack   = 1'b1;
    drdata = 32'hFFFFFFFF;
    #1;
    chk("rr_req_low", {31'd0, dreq}, 32'd0);
    chk("rr_stall", {31'd0, stall}, 32'd0);
    chk("rr_addr", daddr, 32'd0);
    chk("rr_be", {28'd0, dbe}, 32'd0);
    chk("rr_wdata", dwdata, 32'd0);
    chk("rr_we", {31'd0, dwe}, 32'd0);
    tick();
    dack = 1'b0;
    #1;
    chk("rr_done", {31'd0, done}, 32'd0);
    chk("rr_rdata", rdata, 32'd0);
    chk("rr_req_idle", {31'd0, dreq}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
